// File: rtl/wave_meter_pkg.sv
// wave_meter_pkg: FSM state type, default widths and the saturating increment shared by wave_meter.
package wave_meter_pkg;
  localparam int SAMPLE_W_DEF = 16;
  localparam int CNT_W_DEF = 32;
  localparam int CYC_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = w >= 64 ? '1 : (64'd1 << w) - 64'd1;
    return v >= m ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/wave_level_detector.sv
// wave_level_detector: sample level tracker (clk, rst, valid, sample, hyst -> level after this sample, rise strobe); hysteresis band under WAVE_METER_HYST_EN.
module wave_level_detector
  import wave_meter_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [SAMPLE_W-2:0] hyst,
  output logic                       level,
  output logic                       rise
);
  logic held, nxt;
`ifdef WAVE_METER_HYST_EN
  logic signed [SAMPLE_W:0] band, s_ext;
  assign band = $signed({2'b00, hyst});
  assign s_ext = {sample[SAMPLE_W-1], sample};
  // high test first so that HYST=0 sends an exact zero high
  assign nxt = s_ext >= band ? 1'b1 : s_ext <= -band ? 1'b0 : held;
`else
  logic unused_hyst;
  assign unused_hyst = ^hyst;
  assign nxt = !sample[SAMPLE_W-1] && |sample;
`endif
  assign level = valid ? nxt : held;
  assign rise = valid && !held && nxt;
  always_ff @(posedge clk)
    if (rst) held <= 1'b0;
    else if (valid) held <= nxt;
endmodule

// File: rtl/wave_meter.sv
// wave_meter: measures period, high-time and peaks over N rising-crossing cycles of a sample stream.
// Ports: clk, rst (sync, active-high), sample_valid, sample, start, n_cycles, timeout, hyst ->
// busy, done (pulse), timed_out, period_sum, high_sum, peak_max, peak_min. Optional WAVE_METER_HYST_EN.
module wave_meter
  import wave_meter_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       start,
  input  logic        [CYC_W-1:0]    n_cycles,
  input  logic        [CNT_W-1:0]    timeout,
  input  logic        [SAMPLE_W-2:0] hyst,
  output logic                       busy,
  output logic                       done,
  output logic                       timed_out,
  output logic        [CNT_W-1:0]    period_sum,
  output logic        [CNT_W-1:0]    high_sum,
  output logic signed [SAMPLE_W-1:0] peak_max,
  output logic signed [SAMPLE_W-1:0] peak_min
);
  state_t state;
  logic [CYC_W-1:0] cyc, n_lat;
  logic [CNT_W-1:0] to_lat, to_cnt, to_nxt, psum, hsum, p_n, h_n;
  logic signed [SAMPLE_W-1:0] pmax, pmin, max_n, min_n;
  logic lvl, rise, active, first, closing, t_hit, acc, fin;
  wave_level_detector #(.SAMPLE_W(SAMPLE_W)) u_det (
    .clk(clk), .rst(rst), .valid(sample_valid), .sample(sample), .hyst(hyst), .level(lvl), .rise(rise)
  );
  always_comb begin
    active = state == ARM || state == MEASURE;
    first = state == ARM;
    to_nxt = CNT_W'(sat_inc(64'(to_cnt), CNT_W));
    t_hit = to_lat != '0 && to_nxt == to_lat;
    closing = state == MEASURE && rise && cyc + CYC_W'(1) == n_lat;
    // in ARM only the opening crossing enters the window; the closing crossing never does
    acc = sample_valid && (first ? rise : state == MEASURE && !closing);
    p_n = !acc ? psum : first ? CNT_W'(1) : CNT_W'(sat_inc(64'(psum), CNT_W));
    h_n = !(acc && lvl) ? hsum : first ? CNT_W'(1) : CNT_W'(sat_inc(64'(hsum), CNT_W));
    max_n = acc && (first || sample > pmax) ? sample : pmax;
    min_n = acc && (first || sample < pmin) ? sample : pmin;
    fin = sample_valid && active && (closing || t_hit);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      {cyc, n_lat, to_lat, to_cnt, psum, hsum, pmax, pmin} <= '0;
      {busy, done, timed_out, period_sum, high_sum, peak_max, peak_min} <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start && n_cycles != '0) begin
        state <= ARM;
        busy <= 1'b1;
        n_lat <= n_cycles;
        to_lat <= timeout;
        {cyc, to_cnt, psum, hsum, pmax, pmin} <= '0;
      end else if (state == DONE) state <= IDLE;
      else if (active && sample_valid) begin
        to_cnt <= to_nxt;
        psum <= p_n;
        hsum <= h_n;
        pmax <= max_n;
        pmin <= min_n;
        if (state == MEASURE && rise) cyc <= cyc + CYC_W'(1);
        if (first && rise) state <= MEASURE;
        // a closing crossing on the timeout sample wins, so timed_out stays low
        if (fin) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          timed_out <= !closing;
          period_sum <= p_n;
          high_sum <= h_n;
          peak_max <= max_n;
          peak_min <= min_n;
        end
      end
    end
endmodule

// File: tb/tb_wave_meter.sv
// tb_wave_meter: self-checking bench for wave_meter (table vectors, corner sequences, randomized runs vs a window model).
module tb_wave_meter;
  logic clk = 1'b0, rst, sample_valid, start, busy, done, timed_out;
  logic signed [15:0] sample, peak_max, peak_min;
  logic [15:0] n_cycles;
  logic [31:0] timeout, period_sum, high_sum;
  logic [14:0] hyst;
  int passed = 0, total = 0;
  bit mlvl;
  bit sv_q[$];
  int ss_q[$];
  typedef struct {int p; int h; int mx; int mn; bit to;} res_t;
  typedef struct {int hi; int lo; int hl; int ll; int gap; int n; int to; int hy; bit dup; res_t e;} vec_t;
  wave_meter dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample), .start(start),
    .n_cycles(n_cycles), .timeout(timeout), .hyst(hyst), .busy(busy), .done(done),
    .timed_out(timed_out), .period_sum(period_sum), .high_sum(high_sum),
    .peak_max(peak_max), .peak_min(peak_min)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  function automatic bit lvl_rule(input bit prev, input int s, input int hy);
`ifdef WAVE_METER_HYST_EN
    return s >= hy ? 1'b1 : s <= -hy ? 1'b0 : prev;
`else
    return hy < 0 ? prev : s > 0;
`endif
  endfunction
  // window = valid samples from the first crossing up to (not incl.) crossing n, or up to the timeout sample
  function automatic void model(input bit l0, input int n, input int to, input int hy, output res_t r, output int fc);
    int vs[$], vc[$], cr[$];
    bit lv[$];
    bit l;
    int e, tf, lo, hi;
    l = l0;
    for (int k = 0; k < sv_q.size(); k++) if (sv_q[k]) begin
      bit nx;
      nx = lvl_rule(l, ss_q[k], hy);
      if (!l && nx) cr.push_back(vs.size());
      vs.push_back(ss_q[k]);
      vc.push_back(k);
      lv.push_back(nx);
      l = nx;
    end
    r = '{0, 0, 0, 0, 1'b0};
    fc = -1;
    e = cr.size() > n ? cr[n] : -1;
    tf = to != 0 && to <= vs.size() ? to - 1 : -1;
    if (e >= 0 && (tf < 0 || e <= tf)) begin
      fc = vc[e]; lo = cr[0]; hi = e - 1;
    end else if (tf >= 0) begin
      fc = vc[tf]; r.to = 1'b1; lo = cr.size() > 0 ? cr[0] : tf + 1; hi = tf;
    end else return;
    if (lo <= hi) begin
      r.mx = vs[lo];
      r.mn = vs[lo];
    end
    for (int i = lo; i <= hi; i++) begin
      r.p++;
      r.h += int'(lv[i]);
      if (vs[i] > r.mx) r.mx = vs[i];
      if (vs[i] < r.mn) r.mn = vs[i];
    end
  endfunction
  task automatic drive_cycle(input int k);
    sample_valid = sv_q[k];
    sample = 16'(ss_q[k]);
    if (sv_q[k]) mlvl = lvl_rule(mlvl, ss_q[k], int'(hyst));
  endtask
  task automatic make_square(input vec_t v);
    int cnt;
    sv_q.delete();
    ss_q.delete();
    cnt = (v.n + 2) * (v.hl + v.ll) + v.to + 2;
    for (int i = 0; i < cnt; i++) begin
      sv_q.push_back(1'b1);
      ss_q.push_back(i % (v.hl + v.ll) < v.hl ? v.hi : v.lo);
      repeat (v.gap) begin
        sv_q.push_back(1'b0);
        ss_q.push_back(int'($urandom_range(0, 65535)) - 32768);
      end
    end
  endtask
  task automatic gen_rand();
    int len, sgn, seg, amp;
    bit noise;
    sv_q.delete();
    ss_q.delete();
    len = $urandom_range(60, 250);
    sgn = 1;
    while (sv_q.size() < len) begin
      seg = $urandom_range(1, 6);
      amp = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 32767);
      noise = $urandom_range(0, 9) == 0;
      for (int j = 0; j < seg; j++) begin
        sv_q.push_back($urandom_range(0, 3) != 0);
        ss_q.push_back(noise ? int'($urandom_range(0, 65535)) - 32768 : sgn * int'($urandom_range(0, amp)));
      end
      sgn = -sgn;
    end
  endtask
  task automatic run(input string nm, input int n, input int to, input int hy, input bit use_exp, input res_t ex, input bit dup);
    res_t m;
    int fc, got, nd, len, cp, ch, cmx, cmn;
    bit ct, cb;
    len = sv_q.size();
    model(mlvl, n, to, hy, m, fc);
    if (use_exp) m = ex;
    @(negedge clk);
    start = 1'b1; n_cycles = 16'(n); timeout = 32'(to); hyst = 15'(hy); sample_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " busy_rise"}, busy, 1);
    got = -1; nd = 0;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        nd++;
        if (got < 0) begin
          got = k; cp = period_sum; ch = high_sum; cmx = peak_max; cmn = peak_min; ct = timed_out; cb = busy;
        end
      end
      start = dup && k == 3;
      if (dup && k == 3) n_cycles = 16'd1;
      if (k < len) drive_cycle(k);
      else sample_valid = 1'b0;
    end
    if (fc >= 0) begin
      chk({nm, " done_count"}, nd, 1);
      chk({nm, " done_cycle"}, got, fc + 1);
      chk({nm, " period_sum"}, cp, m.p);
      chk({nm, " high_sum"}, ch, m.h);
      chk({nm, " peak_max"}, cmx, m.mx);
      chk({nm, " peak_min"}, cmn, m.mn);
      chk({nm, " timed_out"}, ct, m.to);
      chk({nm, " busy_fall"}, cb, 0);
    end else begin
      chk({nm, " no_done"}, nd, 0);
      @(negedge clk);
      rst = 1'b1; sample_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      mlvl = 1'b0;
      chk({nm, " rst_busy"}, busy, 0);
    end
  endtask
  initial begin
    vec_t tbl[6];
    res_t z;
    int nd;
    z = '{0, 0, 0, 0, 1'b0};
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0; sample = '0; n_cycles = '0; timeout = '0; hyst = '0; mlvl = 1'b0;
    tbl[0] = '{16384, -16384, 4, 4, 0, 3, 0, 0, 1'b0, '{24, 12, 16384, -16384, 1'b0}};
    tbl[1] = '{16384, -16384, 4, 4, 1, 3, 0, 0, 1'b1, '{24, 12, 16384, -16384, 1'b0}};
    tbl[2] = '{0, 0, 1, 1, 0, 1, 100, 1, 1'b0, '{0, 0, 0, 0, 1'b1}};
`ifdef WAVE_METER_HYST_EN
    tbl[3] = '{50, -50, 1, 1, 0, 2, 50, 100, 1'b0, '{0, 0, 0, 0, 1'b1}};
`else
    tbl[3] = '{50, -50, 1, 1, 0, 2, 50, 100, 1'b0, '{4, 2, 50, -50, 1'b0}};
`endif
    tbl[4] = '{1000, -2000, 3, 5, 0, 2, 0, 0, 1'b0, '{16, 6, 1000, -2000, 1'b0}};
    tbl[5] = '{300, -100, 2, 2, 0, 5, 7, 0, 1'b0, '{3, 2, 300, -100, 1'b1}};
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset timed_out", timed_out, 0);
    chk("reset period_sum", period_sum, 0);
    chk("reset high_sum", high_sum, 0);
    chk("reset peak_max", peak_max, 0);
    chk("reset peak_min", peak_min, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      make_square(tbl[i]);
      run($sformatf("vec%0d", i), tbl[i].n, tbl[i].to, tbl[i].hy, 1'b1, tbl[i].e, tbl[i].dup);
    end
    @(negedge clk);
    start = 1'b1; n_cycles = 16'd0; timeout = 32'd0; sample_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("n0 busy", busy, 0);
    chk("n0 done_count", nd, 0);
    make_square(tbl[0]);
    @(negedge clk);
    start = 1'b1; n_cycles = 16'd3; timeout = 32'd0; hyst = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive_cycle(k);
      @(negedge clk);
    end
    chk("mid busy_before_rst", busy, 1);
    rst = 1'b1; sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mlvl = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst timed_out", timed_out, 0);
    chk("rst period_sum", period_sum, 0);
    chk("rst high_sum", high_sum, 0);
    chk("rst peak_max", peak_max, 0);
    chk("rst peak_min", peak_min, 0);
    make_square(tbl[0]);
    run("after_rst", 3, 0, 0, 1'b1, tbl[0].e, 1'b0);
    for (int r = 0; r < 40; r++) begin
      int n, to, hy;
      gen_rand();
      n = $urandom_range(1, 4);
      to = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(5, 150);
      hy = $urandom_range(0, 300);
      run($sformatf("rand%0d", r), n, to, hy, 1'b0, z, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wave_meter.md
# wave_meter

Sample-stream measurement block for a generated 16-bit signed waveform, e.g. a channel's wave output looped back. Detects rising zero crossings, and after a START request measures a programmable number of full cycles. For those cycles it reports the total period in samples, the high-time in samples and the peak min/max. It finishes with a one-cycle DONE pulse. Firmware uses it to check frequency, duty cycle and amplitude of each channel.

## Interface
- SAMPLE_W, 16, sample width (signed)
- CNT_W, 32, width of sample counters and TIMEOUT
- CYC_W, 16, width of N_CYCLES
- CLK  in  1  sample clock
- RST  in  1  synchronous, active-high reset
- SAMPLE_VALID  in  1  SAMPLE is consumed this cycle
- SAMPLE  in  SAMPLE_W  signed sample
- START  in  1  request a measurement; honoured only in IDLE with N_CYCLES != 0
- N_CYCLES  in  CYC_W  number of full cycles to measure; sampled at START
- TIMEOUT  in  CNT_W  abort after this many valid samples since START; 0 disables it; sampled at START
- HYST  in  SAMPLE_W-1  hysteresis half-band (unsigned); ignored unless WAVE_METER_HYST_EN is defined
- BUSY  out  1  high in ARM and MEASURE
- DONE  out  1  one-cycle pulse when the results update
- TIMED_OUT  out  1  result flag: the last measurement aborted on TIMEOUT
- PERIOD_SUM  out  CNT_W  valid samples across the measured cycles
- HIGH_SUM  out  CNT_W  valid samples with level high inside the same window
- PEAK_MAX / PEAK_MIN  out  SAMPLE_W  signed extremes inside the same window

## Operation
- Level tracker runs every valid sample, including in IDLE.
  - Level goes high when SAMPLE > 0.
  - Level goes low when SAMPLE <= 0.
- A rising crossing is a valid sample that moves the level from low to high.
- FSM states are IDLE, ARM, MEASURE and DONE.
- IDLE -> ARM on START with N_CYCLES != 0. On entry: clear the working accumulators, clear the cycle counter and latch N_CYCLES and TIMEOUT. The sample on the START cycle is not processed by the FSM.
- ARM -> MEASURE on a rising crossing. That sample is the first sample of the window. It is counted in PERIOD_SUM and HIGH_SUM and loads both working peaks.
- In MEASURE, each valid sample is checked for a crossing first.
  - If it is a rising crossing, the cycle counter increments.
  - If the counter then equals N_CYCLES, go to DONE. This sample closes the window and is not accumulated.
  - Otherwise the sample is accumulated: +1 to PERIOD_SUM, +1 to HIGH_SUM if level is high after the update, and the peaks update.
- Timeout counter counts valid samples in ARM and MEASURE.
  - When it reaches TIMEOUT (TIMEOUT != 0), go to DONE with TIMED_OUT=1.
  - Results on timeout are the partial window; all zero if still in ARM.
  - If the closing crossing and the timeout land on the same sample, the crossing wins and TIMED_OUT=0.
- DONE lasts one cycle.
  - Copy the working registers to the outputs, assert DONE, then go to IDLE.
  - Outputs hold until the next DONE.
- START outside IDLE, or with N_CYCLES == 0, is ignored.
- Counters saturate at all-ones and never wrap.
- Arithmetic: peaks use signed compares; accumulators are unsigned CNT_W.
- Reset: state IDLE, level low, all counters zero, BUSY=0, DONE=0, TIMED_OUT=0, PERIOD_SUM=0, HIGH_SUM=0, PEAK_MAX=0, PEAK_MIN=0.
- RST mid-measurement drops the measurement. No DONE is produced.

## Timing
- BUSY rises the cycle after an accepted START.
- DONE and the updated results appear the cycle after the closing sample (or the timeout sample) is presented with SAMPLE_VALID.
- BUSY falls in the same cycle as DONE.
- Earliest re-START is accepted in the cycle after DONE.
- SAMPLE_VALID may be low on any cycle. Invalid cycles change nothing, including the timeout counter.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- WAVE_METER_HYST_EN defined:
  - Level goes high only when SAMPLE >= +HYST.
  - Level goes low only when SAMPLE <= -HYST.
  - Inside the band the level holds.
  - HYST=0 is equivalent to high at SAMPLE >= 0 and low at SAMPLE <= 0. A sample of exactly 0 goes high.
- WAVE_METER_HYST_EN undefined: HYST is unused and the level uses the plain > 0 / <= 0 rule above.

## Structure
- Package wave_meter_pkg holds:
  - the FSM state enum (IDLE, ARM, MEASURE, DONE);
  - default widths;
  - the saturating-increment function.
- Sub-module wave_level_detector holds the level register and the hysteresis compare. Its outputs are the level and a rising-crossing strobe, aligned to the input sample.

## Test plan
- Square wave, period 8 samples (4 × +16384, 4 × -16384), N_CYCLES=3, no gaps -> one DONE, PERIOD_SUM=24, HIGH_SUM=12, PEAK_MAX=16384, PEAK_MIN=-16384, TIMED_OUT=0.
- Same stream with SAMPLE_VALID low on every other cycle -> identical results; DONE one cycle after the closing valid sample.
- Constant 0 input, N_CYCLES=1, TIMEOUT=100 -> DONE one cycle after the 100th valid sample, TIMED_OUT=1, all sums and peaks 0.
- Input alternating +50/-50 each sample, N_CYCLES=2, HYST=100, macro defined -> no DONE before TIMEOUT (TIMED_OUT=1). Macro undefined -> DONE with PERIOD_SUM=4, HIGH_SUM=2.
- START while BUSY is ignored. START with N_CYCLES=0 leaves BUSY=0 and produces no DONE.
- RST asserted mid-MEASURE -> next cycle BUSY=0, all outputs 0. A fresh START then measures correctly.
